// File: rtl/pspin_pkt_alloc_mc.sv
// pspin_pkt_alloc_mc: multi-class L2 packet buffer slot allocator. Each class keeps a free-list ring of slot indices.
// Optional per-class low-watermark statistics on class_min_free_o when PSPIN_PKT_ALLOC_STATS_EN is defined.
module pspin_pkt_alloc_mc #(
  parameter int unsigned                         NUM_CLASSES = 3,
  parameter int unsigned                         LEN_WIDTH   = 20,
  parameter int unsigned                         ADDR_WIDTH  = 32,
  parameter int unsigned                         TAG_WIDTH   = 8,
  parameter int unsigned                         CNT_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0]               BUF_START   = 32'h1c100000,
  parameter int unsigned                         BUF_SIZE    = 1048576,
  parameter logic [NUM_CLASSES*LEN_WIDTH-1:0]    CLASS_SIZE  = {20'd1536, 20'd512, 20'd64},
  parameter logic [NUM_CLASSES*CNT_WIDTH-1:0]    CLASS_COUNT = {16'd384, 16'd256, 16'd4096}
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [LEN_WIDTH-1:0]             pkt_len_i,
  input  logic                             pkt_valid_i,
  output logic                             pkt_ready_o,
  input  logic                             feedback_valid_i,
  output logic                             feedback_ready_o,
  input  logic [ADDR_WIDTH-1:0]            feedback_her_addr_i,
  input  logic [LEN_WIDTH-1:0]             feedback_her_size_i,
  output logic [ADDR_WIDTH-1:0]            write_addr_o,
  output logic [LEN_WIDTH-1:0]             write_len_o,
  output logic [TAG_WIDTH-1:0]             write_tag_o,
  output logic                             write_valid_o,
  input  logic                             write_ready_i,
  output logic                             init_done_o,
  output logic [31:0]                      dropped_pkts_o,
  output logic [31:0]                      dropped_nomem_o,
  output logic [31:0]                      bad_feedback_o,
  output logic [NUM_CLASSES*CNT_WIDTH-1:0] class_min_free_o
);

  function automatic logic [63:0] csize(input int unsigned c);
    return 64'(CLASS_SIZE[c*LEN_WIDTH +: LEN_WIDTH]);
  endfunction

  function automatic logic [63:0] ccount(input int unsigned c);
    return 64'(CLASS_COUNT[c*CNT_WIDTH +: CNT_WIDTH]);
  endfunction

  function automatic logic [63:0] cbase_off(input int unsigned c);
    logic [63:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < c; k++) acc += csize(k) * ccount(k);
    return acc;
  endfunction

  function automatic logic [63:0] max_count();
    logic [63:0] m;
    m = '0;
    for (int unsigned k = 0; k < NUM_CLASSES; k++) if (ccount(k) > m) m = ccount(k);
    return m;
  endfunction

  localparam logic [63:0]          TOTAL     = cbase_off(NUM_CLASSES);
  localparam logic [63:0]          MAX_CNT   = max_count();
  localparam logic [CNT_WIDTH-1:0] INIT_LAST = CNT_WIDTH'(MAX_CNT - 64'd1);
  localparam logic [LEN_WIDTH-1:0] MAX_SZ    = CLASS_SIZE[(NUM_CLASSES-1)*LEN_WIDTH +: LEN_WIDTH];

  if (TOTAL > 64'(BUF_SIZE)) begin : g_err_total
    $error("pspin_pkt_alloc_mc: class layout exceeds BUF_SIZE");
  end
  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_chk
    if (csize(c) == 64'd0 || (csize(c) % 64) != 64'd0 || ccount(c) == 64'd0) begin : g_err_cls
      $error("pspin_pkt_alloc_mc: class sizes must be nonzero 64B multiples and counts >= 1");
    end
    if (c > 0) begin : g_asc
      if (csize(c) <= csize(c - 1)) begin : g_err_asc
        $error("pspin_pkt_alloc_mc: class sizes must be strictly ascending");
      end
    end
  end

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 st, st_nxt;
  logic [CNT_WIDTH-1:0]   init_cnt;
  logic [NUM_CLASSES-1:0] fits, avail, pop, fb_ok;
  logic [ADDR_WIDTH-1:0]  alloc_addr [NUM_CLASSES];
  logic                   pkt_accept, fb_accept, len_bad, found, alloc, nomem, bad_fb;
  logic [ADDR_WIDTH-1:0]  addr_sel;
  logic [LEN_WIDTH-1:0]   len_sel;
  logic [TAG_WIDTH-1:0]   seq;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= ST_INIT;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (st == ST_INIT && init_cnt == INIT_LAST) st_nxt = ST_RUN;
  end

  always_comb begin
    pkt_ready_o      = 1'b0;
    feedback_ready_o = 1'b0;
    init_done_o      = 1'b0;
    if (st == ST_RUN) begin
      pkt_ready_o      = !write_valid_o || write_ready_i;
      feedback_ready_o = 1'b1;
      init_done_o      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              init_cnt <= '0;
    else if (st == ST_INIT) init_cnt <= init_cnt + 1'b1;
  end

  assign pkt_accept = pkt_valid_i && pkt_ready_o;
  assign fb_accept  = feedback_valid_i && feedback_ready_o;
  assign len_bad    = (pkt_len_i == '0) || (pkt_len_i > MAX_SZ);

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
    localparam logic [LEN_WIDTH-1:0]  SZ    = CLASS_SIZE[c*LEN_WIDTH +: LEN_WIDTH];
    localparam int unsigned           DEPTH = 32'(ccount(c));
    localparam int unsigned           AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0]  CNT   = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  LAST  = CNT_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE  = BUF_START + ADDR_WIDTH'(cbase_off(c));
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(csize(c) * ccount(c));
    localparam logic [ADDR_WIDTH-1:0] SZ_A  = ADDR_WIDTH'(csize(c));
    localparam bit                    POW2  = (csize(c) & (csize(c) - 64'd1)) == 64'd0;

    logic [CNT_WIDTH-1:0]  mem [DEPTH];
    logic [CNT_WIDTH-1:0]  rd_ptr, wr_ptr, count, fb_idx, push_idx, head;
    logic [ADDR_WIDTH-1:0] off;
    logic                  aligned, push, init_push;

    assign head = mem[rd_ptr[AW-1:0]];
    assign off  = feedback_her_addr_i - BASE;

    if (POW2) begin : g_shift
      localparam int unsigned LG = $clog2(csize(c));
      assign fb_idx        = CNT_WIDTH'(off >> LG);
      assign aligned       = (off & (SZ_A - 1'b1)) == '0;
      assign alloc_addr[c] = BASE + (ADDR_WIDTH'(head) << LG);
    end else begin : g_mul
      assign fb_idx        = CNT_WIDTH'(off / SZ_A);
      assign aligned       = (off % SZ_A) == '0;
      assign alloc_addr[c] = BASE + ADDR_WIDTH'(head) * SZ_A;
    end

    assign fits[c]  = pkt_len_i <= SZ;
    assign avail[c] = count != '0;
    // Fullness uses the pre-cycle count, so a duplicate free of a full class is rejected.
    assign fb_ok[c] = (feedback_her_size_i == SZ) && (feedback_her_addr_i >= BASE) &&
                      (off < SPAN) && aligned && (count < CNT);

    assign init_push = (st == ST_INIT) && (init_cnt < CNT);
    assign push      = init_push || (fb_accept && fb_ok[c]);
    assign push_idx  = init_push ? init_cnt : fb_idx;

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_idx;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)   wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        if (pop[c]) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        if (push != pop[c]) count <= push ? count + 1'b1 : count - 1'b1;
      end
    end

`ifdef PSPIN_PKT_ALLOC_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_nxt, min_free;

    always_comb begin
      cnt_nxt = count;
      if (push && !pop[c])      cnt_nxt = count + 1'b1;
      else if (!push && pop[c]) cnt_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                   min_free <= '0;
      else if (st == ST_INIT && st_nxt == ST_RUN)  min_free <= CNT;
      else if (st == ST_RUN && cnt_nxt < min_free) min_free <= cnt_nxt;
    end

    assign class_min_free_o[c*CNT_WIDTH +: CNT_WIDTH] = min_free;
`else
    assign class_min_free_o[c*CNT_WIDTH +: CNT_WIDTH] = '0;
`endif
  end

  // Smallest class that fits and has a free slot wins; pop is one-hot.
  always_comb begin
    pop      = '0;
    found    = 1'b0;
    addr_sel = '0;
    len_sel  = '0;
    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
      if (!found && fits[i] && avail[i]) begin
        found    = 1'b1;
        pop[i]   = pkt_accept && !len_bad;
        addr_sel = alloc_addr[i];
        len_sel  = CLASS_SIZE[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign alloc  = |pop;
  assign nomem  = pkt_accept && !len_bad && !found;
  assign bad_fb = fb_accept && !(|fb_ok);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_valid_o <= 1'b0;
      write_addr_o  <= '0;
      write_len_o   <= '0;
      write_tag_o   <= '0;
      seq           <= '0;
    end else if (alloc) begin
      write_valid_o <= 1'b1;
      write_addr_o  <= addr_sel;
      write_len_o   <= len_sel;
      write_tag_o   <= seq;
      seq           <= seq + 1'b1;
    end else if (write_ready_i) begin
      write_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dropped_pkts_o  <= '0;
      dropped_nomem_o <= '0;
      bad_feedback_o  <= '0;
    end else begin
      if (pkt_accept && len_bad && dropped_pkts_o != '1) dropped_pkts_o  <= dropped_pkts_o + 1'b1;
      if (nomem && dropped_nomem_o != '1)                dropped_nomem_o <= dropped_nomem_o + 1'b1;
      if (bad_fb && bad_feedback_o != '1)                bad_feedback_o  <= bad_feedback_o + 1'b1;
    end
  end

endmodule
